conv_stream_mc: RTL and testbench

- Multi-bit, multi-channel 2-D convolution engine.
- Slides a KxK window with configurable stride over a flat unsigned image bus.
- Multiplies each window by per-channel signed weights, one tap per cycle, and streams one result vector per output position over a valid/ready handshake.
- Sits after image capture and before pooling/dense stages; weights are loaded at run time through a write port.

---
 rtl/conv_stream_mc.sv | 156 +++++++++++++++
 tb/tb_conv_stream_mc.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/conv_stream_mc.sv
// conv_stream_mc: KxK strided multi-channel convolution over a flat image bus, one tap per cycle.
// Optional macro CONV_RELU_EN clamps negative channel sums to zero when the result is registered.
module conv_stream_mc #(
  parameter int IMG_W    = 8,
  parameter int IMG_H    = 8,
  parameter int K        = 3,
  parameter int STRIDE   = 1,
  parameter int PIX_BITS = 4,
  parameter int W_BITS   = 4,
  parameter int NUM_CH   = 2,
  parameter int ACC_BITS = PIX_BITS + W_BITS + $clog2(K*K) + 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [IMG_W*IMG_H*PIX_BITS-1:0] input_matrix,
  input  logic                         w_we,
  input  logic [$clog2(NUM_CH*K*K)-1:0] w_addr,
  input  logic [W_BITS-1:0]            w_data,
  output logic                         busy,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NUM_CH*ACC_BITS-1:0]   out_data,
  output logic                         out_last,
  output logic                         done
);

  localparam int KK    = K * K;
  localparam int NW    = NUM_CH * KK;
  localparam int OUT_W = (IMG_W - K) / STRIDE + 1;
  localparam int OUT_H = (IMG_H - K) / STRIDE + 1;
  localparam int TAP_W = $clog2(KK + 1);
  localparam int COL_W = $clog2(OUT_W + 1);
  localparam int ROW_W = $clog2(OUT_H + 1);

  typedef enum logic [1:0] {IDLE, ACCUM, OUTPUT, FINISHED} state_t;

  state_t                     state_q;
  logic [TAP_W-1:0]           tap_q;
  logic [COL_W-1:0]           col_q;
  logic [ROW_W-1:0]           row_q;
  logic signed [ACC_BITS-1:0] acc_q [NUM_CH];
  logic signed [ACC_BITS-1:0] acc_d [NUM_CH];
  logic signed [W_BITS-1:0]   w_q   [NW];
  logic signed [ACC_BITS-1:0] w_ext [NUM_CH];
  logic signed [ACC_BITS-1:0] pix_ext;
  logic [PIX_BITS-1:0]        pix;
  logic [NUM_CH*ACC_BITS-1:0] res_d;
  logic                       busy_q, out_valid_q, out_last_q, done_q;
  logic [NUM_CH*ACC_BITS-1:0] out_data_q;
  logic                       last_pos;
  int                         pix_x, pix_y, pix_idx;

  // Current tap's pixel: window origin (col,row)*STRIDE plus row-major offset within the kernel.
  always_comb begin
    pix_x   = int'(col_q) * STRIDE + int'(tap_q) % K;
    pix_y   = int'(row_q) * STRIDE + int'(tap_q) / K;
    pix_idx = pix_y * IMG_W + pix_x;
    pix     = input_matrix[pix_idx*PIX_BITS +: PIX_BITS];
    pix_ext = $signed({{(ACC_BITS-PIX_BITS){1'b0}}, pix});
  end

  always_comb begin
    res_d = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      w_ext[ch] = {{(ACC_BITS-W_BITS){w_q[ch*KK + int'(tap_q)][W_BITS-1]}}, w_q[ch*KK + int'(tap_q)]};
      acc_d[ch] = acc_q[ch] + pix_ext * w_ext[ch];
`ifdef CONV_RELU_EN
      res_d[ch*ACC_BITS +: ACC_BITS] = acc_d[ch][ACC_BITS-1] ? '0 : acc_d[ch];
`else
      res_d[ch*ACC_BITS +: ACC_BITS] = acc_d[ch];
`endif
    end
  end

  assign last_pos = (row_q == ROW_W'(OUT_H - 1)) && (col_q == COL_W'(OUT_W - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      tap_q       <= '0;
      col_q       <= '0;
      row_q       <= '0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
      out_data_q  <= '0;
      for (int ch = 0; ch < NUM_CH; ch++) acc_q[ch] <= '0;
      for (int i = 0; i < NW; i++) w_q[i] <= '0;
    end else begin
      // Weights are frozen while a frame is in flight.
      if (w_we && (state_q == IDLE || state_q == FINISHED) && (int'(w_addr) < NW))
        w_q[w_addr] <= w_data;

      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= ACCUM;
            busy_q  <= 1'b1;
            tap_q   <= '0;
            col_q   <= '0;
            row_q   <= '0;
            for (int ch = 0; ch < NUM_CH; ch++) acc_q[ch] <= '0;
          end
        end
        ACCUM: begin
          for (int ch = 0; ch < NUM_CH; ch++) acc_q[ch] <= acc_d[ch];
          if (tap_q == TAP_W'(KK - 1)) begin
            tap_q       <= '0;
            out_data_q  <= res_d;
            out_valid_q <= 1'b1;
            out_last_q  <= last_pos;
            state_q     <= OUTPUT;
          end else begin
            tap_q <= tap_q + TAP_W'(1);
          end
        end
        OUTPUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            for (int ch = 0; ch < NUM_CH; ch++) acc_q[ch] <= '0;
            if (out_last_q) begin
              state_q <= FINISHED;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= ACCUM;
              if (col_q == COL_W'(OUT_W - 1)) begin
                col_q <= '0;
                row_q <= row_q + ROW_W'(1);
              end else begin
                col_q <= col_q + COL_W'(1);
              end
            end
          end
        end
        FINISHED: begin
          if (!start) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_data  = out_data_q;
  assign done      = done_q;

endmodule

// File: tb/tb_conv_stream_mc.sv
// Bench for conv_stream_mc: 5x5 image, K=3, stride 2 (2x2 outputs), reference model from plain window sums.
module tb_conv_stream_mc;

  localparam int IW = 5, IH = 5, K = 3, ST = 2, PB = 4, WB = 4, NC = 2;
  localparam int AB = PB + WB + $clog2(K*K) + 1;
  localparam int KK = K * K, NW = NC * KK;
  localparam int OW = (IW - K) / ST + 1, OH = (IH - K) / ST + 1, NPOS = OW * OH;
  localparam int AWD = $clog2(NW);

  logic clk = 1'b0;
  logic rst, start, w_we, out_ready;
  logic [IW*IH*PB-1:0] input_matrix;
  logic [AWD-1:0] w_addr;
  logic [WB-1:0] w_data;
  logic busy, out_valid, out_last, done;
  logic [NC*AB-1:0] out_data;

  int img [IW*IH];
  int wm  [NW];
  int n_cmp = 0, n_bad = 0;

  conv_stream_mc #(.IMG_W(IW), .IMG_H(IH), .K(K), .STRIDE(ST), .PIX_BITS(PB),
                   .W_BITS(WB), .NUM_CH(NC)) dut (
    .clk(clk), .rst(rst), .start(start), .input_matrix(input_matrix),
    .w_we(w_we), .w_addr(w_addr), .w_data(w_data), .busy(busy),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .done(done));

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint model(input int ch, input int r, input int c);
    longint s = 0;
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++)
        s += longint'(img[(r*ST + i)*IW + c*ST + j]) * longint'(wm[ch*KK + i*K + j]);
`ifdef CONV_RELU_EN
    if (s < 0) s = 0;
`endif
    return s;
  endfunction

  task automatic load_img();
    for (int i = 0; i < IW*IH; i++) input_matrix[i*PB +: PB] = PB'(img[i]);
  endtask

  task automatic wr(input int a, input int d);
    w_we = 1'b1; w_addr = AWD'(a); w_data = WB'(d);
    @(posedge clk); #1;
    w_we = 1'b0;
    if (a < NW) wm[a] = int'($signed(w_data));
  endtask

  // mode 0: ready tied high with latency checks; 1: random ready and weight-write noise; 2: 5-cycle stall on first vector
  task automatic run_frame(input int mode);
    int n, cyc, stall;
    bit seen, rdy;
    logic [NC*AB-1:0] held;
    logic held_last;
    n = 0; cyc = 0; stall = 0; seen = 0;
    start = 1'b1;
    out_ready = (mode != 1);
    @(posedge clk); #1;
    check("busy_entry", busy, 1);
    while (n < NPOS && cyc < 3000) begin
      if (mode == 1) begin
        w_we = 1'(($urandom % 2)); w_addr = AWD'($urandom); w_data = WB'($urandom);
      end
      if (out_valid) begin
        if (!seen) begin
          seen = 1; held = out_data; held_last = out_last;
          for (int ch = 0; ch < NC; ch++)
            check($sformatf("data_p%0d_ch%0d", n, ch),
                  longint'($signed(out_data[ch*AB +: AB])), model(ch, n / OW, n % OW));
          check($sformatf("last_p%0d", n), out_last, (n == NPOS - 1));
          if (mode == 0) check($sformatf("lat_p%0d", n), cyc, KK + (KK + 1) * n);
        end else begin
          check("hold_data", out_data, held);
          check("hold_last", out_last, held_last);
        end
        if (mode == 1) rdy = 1'(($urandom % 2));
        else if (mode == 2 && n == 0 && stall < 5) begin rdy = 0; stall++; end
        else rdy = 1;
        out_ready = rdy;
        @(posedge clk); #1; cyc++;
        if (rdy) begin
          n++; seen = 0;
          if (n < NPOS) check("valid_drop", out_valid, 0);
        end
      end else begin
        out_ready = (mode == 1) ? 1'(($urandom % 2)) : 1'b1;
        @(posedge clk); #1; cyc++;
      end
    end
    w_we = 1'b0;
    out_ready = 1'b0;
    check("frame_timeout", (cyc < 3000), 1);
    check("done_set", done, 1);
    check("busy_clr", busy, 0);
    check("valid_after_frame", out_valid, 0);
  endtask

  task automatic finish_frame(input int hold);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("done_hold", done, 1);
      check("no_restart", busy, 0);
    end
    start = 1'b0;
    @(posedge clk); #1;
    check("done_clr", done, 0);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; w_we = 1'b0; out_ready = 1'b0;
    w_addr = '0; w_data = '0; input_matrix = '0;
    for (int i = 0; i < NW; i++) wm[i] = 0;
    repeat (3) @(posedge clk); #1;
    check("rst_busy", busy, 0);
    check("rst_valid", out_valid, 0);
    check("rst_last", out_last, 0);
    check("rst_done", done, 0);
    check("rst_data", out_data, 0);
    rst = 1'b1;

    // All-ones image, +1 / -1 kernels
    for (int i = 0; i < IW*IH; i++) img[i] = 1;
    load_img();
    for (int t = 0; t < KK; t++) begin wr(t, 1); wr(KK + t, -1); end
    run_frame(0);
    finish_frame(2);

    // pixel = x+y, centre tap only on ch0, with backpressure on the first vector
    for (int y = 0; y < IH; y++) for (int x = 0; x < IW; x++) img[y*IW + x] = x + y;
    load_img();
    for (int t = 0; t < KK; t++) wr(t, (t == KK/2) ? 1 : 0);
    run_frame(2);
    finish_frame(1);

    // Extremes: 15 * -8 * 9, then +7 loaded while FINISHED with start still high
    for (int i = 0; i < IW*IH; i++) img[i] = 15;
    load_img();
    for (int i = 0; i < NW; i++) wr(i, -8);
    run_frame(0);
    for (int i = 0; i < NW; i++) wr(i, 7);
    wr(NW + 3, 5);
    check("fin_writes_no_restart", busy, 0);
    finish_frame(3);
    run_frame(0);
    finish_frame(1);

    // Random frames with handshake jitter and ignored in-frame writes
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < IW*IH; i++) img[i] = int'($urandom_range(0, 15));
      load_img();
      for (int i = 0; i < NW; i++) wr(i, int'($urandom_range(0, 15)));
      wr(int'($urandom_range(NW, 31)), int'($urandom_range(0, 15)));
      run_frame(1);
      finish_frame(int'($urandom_range(0, 2)));
    end

    // Reset in the middle of position 2's accumulation
    out_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    repeat (25) @(posedge clk); #1;
    check("mid_accum_busy", busy, 1);
    rst = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    check("mrst_busy", busy, 0);
    check("mrst_valid", out_valid, 0);
    check("mrst_last", out_last, 0);
    check("mrst_done", done, 0);
    check("mrst_data", out_data, 0);
    rst = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < NW; i++) wm[i] = 0;
    run_frame(0);
    finish_frame(1);
    for (int i = 0; i < NW; i++) wr(i, int'($urandom_range(0, 15)));
    run_frame(0);
    finish_frame(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
